// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fetch_pkg;

  // Fetch FSM states: request, wait for data, hold for decode, drop a stale response.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/pc_incrementer.sv
// Sequential-PC adder: pc + INSTR_BYTES, modulo 2^ADDR_WIDTH, carry discarded.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: pc (current PC), pc_next (pc + 4, wraps to 0 past the top of the space).
module pc_incrementer
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_next
);

  assign pc_next = pc + ADDR_WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches one instruction at a time from imem at the PC and buffers it for decode.
// Latency: response in cycle N -> instr_valid in cycle N+1; best case 3 cycles/instr.
// Backpressure: single-entry buffer; no new request is issued while decode stalls.
// Ports: clock/reset (async, active low); imem_req_* request port (valid/ready);
//        imem_resp_* response port (never back-pressured); redirect_* PC load;
//        instr_* buffered instruction with its PC (valid/ready).
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_resp_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] redirect_aligned;
  logic                  req_hs;
  logic                  resp_take;
  logic                  redirect_lsb_unused;

  pc_incrementer #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_inc (
    .pc      (pc_q),
    .pc_next (pc_inc)
  );

  // Targets are word aligned; the low two bits of the redirect are dropped.
  assign redirect_aligned    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Gated with reset so the request is low for the whole reset interval,
  // even though the state register already sits in S_REQ.
  assign imem_req_valid = reset && (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (state_q == S_HOLD);

  assign req_hs    = (state_q == S_REQ) && imem_req_ready;
  // A response is only kept when no redirect arrives in the same cycle.
  assign resp_take = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (req_hs) state_d = redirect_valid ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid)       state_d = imem_resp_valid ? S_REQ : S_DRAIN;
        else if (imem_resp_valid) state_d = S_HOLD;
      end
      S_HOLD: begin
        // Redirect wins over instr_ready: the buffered instruction is dropped.
        if (redirect_valid || instr_ready) state_d = S_REQ;
      end
      S_DRAIN: begin
        if (imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_data <= '0;
      instr_pc   <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid)  pc_q <= redirect_aligned;
      else if (resp_take)  pc_q <= pc_inc;
      if (resp_take) begin
        instr_data <= imem_resp_data;
        instr_pc   <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, stall, redirects, wrap, async reset.
// Latency: memory model answers one cycle after each accepted request.
// Backpressure: decode ready driven per scenario; memory request ready held high.
module tb_instruction_fetch_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Main DUT (RESET_PC = 0)
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data;
  logic [63:0] instr_pc;

  instruction_fetch_unit #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  // Memory model: responds with addr ^ A5A5_0000 one cycle after accept.
  logic        pend;
  logic [63:0] pend_addr;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend      <= 1'b0;
      pend_addr <= '0;
    end else begin
      pend      <= imem_req_valid && imem_req_ready;
      pend_addr <= imem_req_addr;
    end
  end
  assign imem_resp_valid = pend;
  assign imem_resp_data  = pend_addr[31:0] ^ 32'hA5A5_0000;

  // Wrap-around DUT (RESET_PC at top of address space), free running
  logic        w_rst_n;
  logic        w_req_valid;
  logic [63:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_instr_valid;
  logic [31:0] w_instr_data;
  logic [63:0] w_instr_pc;
  logic        w_pend;
  logic [63:0] w_pend_addr;

  instruction_fetch_unit #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clock(clock), .reset(w_rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .redirect_valid(1'b0), .redirect_pc(64'h0),
    .instr_valid(w_instr_valid), .instr_ready(1'b1),
    .instr_data(w_instr_data), .instr_pc(w_instr_pc)
  );

  always @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      w_pend      <= 1'b0;
      w_pend_addr <= '0;
    end else begin
      w_pend      <= w_req_valid;
      w_pend_addr <= w_req_addr;
    end
  end
  assign w_resp_valid = w_pend;
  assign w_resp_data  = w_pend_addr[31:0] ^ 32'hA5A5_0000;

  // Waits (bounded) for the next negedge at which instr_valid is high.
  task automatic get_instr(input int budget, output bit found, output logic [63:0] pc,
                           output logic [31:0] data, output int at);
    found = 1'b0; pc = '0; data = '0; at = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (instr_valid) begin
        found = 1'b1; pc = instr_pc; data = instr_data; at = cyc;
        break;
      end
    end
  endtask

  task automatic get_instr_w(input int budget, output bit found, output logic [63:0] pc,
                             output logic [31:0] data);
    found = 1'b0; pc = '0; data = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (w_instr_valid) begin
        found = 1'b1; pc = w_instr_pc; data = w_instr_data;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 0", imem_req_addr); end
    checks++; if (instr_pc !== 64'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_instr_data: got %h want 0", instr_data); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL first_req_addr: got %h want 0", imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc [4] = '{64'h0, 64'h4, 64'h8, 64'hC};
    logic [31:0] exp_dat[4] = '{32'hA5A5_0000, 32'hA5A5_0004, 32'hA5A5_0008, 32'hA5A5_000C};
    bit f; logic [63:0] p; logic [31:0] d; int at; int prev_at;
    prev_at = 0;
    for (int k = 0; k < 4; k++) begin
      get_instr(12, f, p, d, at);
      checks++; if (!f) begin errors++; $display("FAIL stream_found[%0d]: got none want instr", k); end
      checks++; if (p !== exp_pc[k]) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", k, p, exp_pc[k]); end
      checks++; if (d !== exp_dat[k]) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", k, d, exp_dat[k]); end
      if (k > 0) begin
        checks++; if (at - prev_at != 3) begin errors++; $display("FAIL stream_gap[%0d]: got %0d want 3", k, at - prev_at); end
      end
      prev_at = at;
    end
  endtask

  task automatic test_stall();
    bit f; bit found8; logic [63:0] p; logic [31:0] d; int at;
    do_reset();
    found8 = 1'b0;
    for (int k = 0; k < 4 && !found8; k++) begin
      get_instr(12, f, p, d, at);
      if (f && p == 64'h8) found8 = 1'b1;
    end
    instr_ready = 1'b0;
    checks++; if (!found8) begin errors++; $display("FAIL stall_reach_pc8: got none want pc 8"); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 64'h8 || instr_data !== 32'hA5A5_0008)
        begin errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h d=%h want v=1 pc=8 d=a5a50008", k, instr_valid, instr_pc, instr_data); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_no_req[%0d]: got %b want 0", k, imem_req_valid); end
    end
    instr_ready = 1'b1;
    @(negedge clock);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hC)
      begin errors++; $display("FAIL stall_next_req: got v=%b a=%h want v=1 a=c", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    bit f; logic [63:0] p; logic [31:0] d; int at;
    @(negedge clock);
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
      begin errors++; $display("FAIL rwait_in_wait: got req=%b iv=%b want 0 0", imem_req_valid, instr_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h1003;
    @(negedge clock);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rwait_dropped: got %b want 0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000)
      begin errors++; $display("FAIL rwait_req: got v=%b a=%h want v=1 a=1000", imem_req_valid, imem_req_addr); end
    get_instr(12, f, p, d, at);
    checks++; if (!f || p !== 64'h1000 || d !== 32'hA5A5_1000)
      begin errors++; $display("FAIL rwait_instr: got f=%b pc=%h d=%h want pc=1000 d=a5a51000", f, p, d); end
  endtask

  task automatic test_redirect_hs();
    bit f; logic [63:0] p; logic [31:0] d; int at;
    @(negedge clock);
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1004)
      begin errors++; $display("FAIL rhs_req: got v=%b a=%h want v=1 a=1004", imem_req_valid, imem_req_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    @(negedge clock);
    redirect_valid = 1'b0;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
      begin errors++; $display("FAIL rhs_drain: got req=%b iv=%b want 0 0", imem_req_valid, instr_valid); end
    @(negedge clock);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rhs_discard: got %b want 0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h2000)
      begin errors++; $display("FAIL rhs_target_req: got v=%b a=%h want v=1 a=2000", imem_req_valid, imem_req_addr); end
    get_instr(12, f, p, d, at);
    checks++; if (!f || p !== 64'h2000 || d !== 32'hA5A5_2000)
      begin errors++; $display("FAIL rhs_instr: got f=%b pc=%h d=%h want pc=2000 d=a5a52000", f, p, d); end
  endtask

  task automatic test_redirect_hold();
    bit f; logic [63:0] p; logic [31:0] d; int at;
    // Still at the negedge where pc 0x2000 is held; redirect with instr_ready=1.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    @(negedge clock);
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rhold_not_delivered: got %b want 0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h3000)
      begin errors++; $display("FAIL rhold_req: got v=%b a=%h want v=1 a=3000", imem_req_valid, imem_req_addr); end
    get_instr(12, f, p, d, at);
    checks++; if (!f || p !== 64'h3000 || d !== 32'hA5A5_3000)
      begin errors++; $display("FAIL rhold_instr: got f=%b pc=%h d=%h want pc=3000 d=a5a53000", f, p, d); end
  endtask

  task automatic test_async_reset();
    bit f; logic [63:0] p; logic [31:0] d; int at;
    @(negedge clock);   // back in S_REQ, handshake at next edge
    @(negedge clock);   // now in S_WAIT
    #2;
    reset = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
      begin errors++; $display("FAIL areset_valids: got req=%b iv=%b want 0 0", imem_req_valid, instr_valid); end
    checks++; if (imem_req_addr !== 64'h0) begin errors++; $display("FAIL areset_addr: got %h want 0", imem_req_addr); end
    checks++; if (instr_pc !== 64'h0 || instr_data !== 32'h0)
      begin errors++; $display("FAIL areset_buf: got pc=%h d=%h want 0 0", instr_pc, instr_data); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0)
      begin errors++; $display("FAIL areset_first_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
    get_instr(12, f, p, d, at);
    checks++; if (!f || p !== 64'h0 || d !== 32'hA5A5_0000)
      begin errors++; $display("FAIL areset_instr: got f=%b pc=%h d=%h want pc=0 d=a5a50000", f, p, d); end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_pc [3] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
    logic [31:0] exp_dat[3] = '{32'h5A5A_FFFC, 32'hA5A5_0000, 32'hA5A5_0004};
    bit f; logic [63:0] p; logic [31:0] d;
    @(negedge clock);
    checks++; if (w_req_valid !== 1'b0 || w_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      begin errors++; $display("FAIL wrap_reset: got v=%b a=%h want v=0 a=fffffffffffffffc", w_req_valid, w_req_addr); end
    w_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      get_instr_w(12, f, p, d);
      checks++; if (!f || p !== exp_pc[k] || d !== exp_dat[k])
        begin errors++; $display("FAIL wrap_instr[%0d]: got f=%b pc=%h d=%h want pc=%h d=%h", k, f, p, d, exp_pc[k], exp_dat[k]); end
    end
  endtask

  initial begin
    reset          = 1'b0;
    w_rst_n        = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_hs();
    test_redirect_hold();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Consumer side of the program-counter path: owns the 64-bit PC, reads instruction memory at the PC over a valid/ready request port, and hands each fetched instruction downstream with its PC. It advances the PC by 4 after every fetch and accepts redirects for branches and jumps. One request is outstanding at a time, and a single-entry output buffer decouples it from the decode stage.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, PC and memory address width.
- `INSTR_WIDTH`, 32, instruction word width.
- `RESET_PC`, 64'h0, PC loaded at reset; bits [1:0] must be 0.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  request to instruction memory.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  ADDR_WIDTH  fetch address; equals the current PC.
- `imem_resp_valid`  in  1  response data valid. Memory never back-pressures responses.
- `imem_resp_data`  in  INSTR_WIDTH  instruction word.
- `redirect_valid`  in  1  load a new PC.
- `redirect_pc`  in  ADDR_WIDTH  redirect target; bits [1:0] are ignored and forced to 0.
- `instr_valid`  out  1  output buffer holds an instruction.
- `instr_ready`  in  1  decode accepts the instruction.
- `instr_data`  out  INSTR_WIDTH  buffered instruction.
- `instr_pc`  out  ADDR_WIDTH  PC of the buffered instruction.

## Operation
States:
- `S_REQ`
  - Drive `imem_req_valid=1`, `imem_req_addr=pc`.
  - On `imem_req_ready`, go to `S_WAIT`.
- `S_WAIT`
  - On `imem_resp_valid`: load `imem_resp_data` into the buffer and `pc` into `instr_pc`; set `pc <= pc+4`; go to `S_HOLD`.
- `S_HOLD`
  - Drive `instr_valid=1`.
  - On `instr_ready`, clear the buffer and go to `S_REQ`.
- `S_DRAIN`
  - A request is in flight but stale.
  - On `imem_resp_valid`, discard the data and go to `S_REQ`.

Redirect has priority over every other event in the same cycle:
- `pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}`.
- The output buffer is invalidated, even if `instr_ready` is high in that cycle, so the old instruction is not consumed.
- Next state depends on the current state:
  - `S_REQ` with no handshake this cycle: stay in `S_REQ`.
  - `S_REQ` with handshake this cycle: go to `S_DRAIN`.
  - `S_WAIT`, whether or not a response arrives this cycle: go to `S_DRAIN`, or to `S_REQ` if the response arrives this cycle (it is discarded).
  - `S_HOLD`: go to `S_REQ`.
  - `S_DRAIN`: stay in `S_DRAIN`, or go to `S_REQ` if the response arrives this cycle.

Arithmetic:
- PC increment is modulo 2^ADDR_WIDTH with no carry-out or flag.
- `64'hFFFF_FFFF_FFFF_FFFC + 4 = 0`.
- A response arriving in `S_REQ` or `S_HOLD` is a protocol violation and is ignored.

## Timing
- Reset values while `reset` is low:
  - `imem_req_valid=0`, `instr_valid=0`.
  - `imem_req_addr=RESET_PC`, `instr_pc=0`, `instr_data=0`.
  - State `S_REQ`.
- Reset mid-operation aborts immediately. Any in-flight response after reset release is not tracked; memory must be reset together with this block.
- In the first cycle after reset release, `imem_req_valid=1`.
- Latency: response in cycle N gives `instr_valid=1` in cycle N+1 (registered).
- Best-case throughput: one instruction per 3 cycles (`REQ`→`WAIT`→`HOLD`) with zero-wait memory and `instr_ready` tied high.
- `imem_req_valid` and `imem_req_addr` stay stable until the handshake; they change only on redirect.
- `instr_valid`, `instr_data` and `instr_pc` stay stable while `instr_ready=0`.

## Structure
- Package `fetch_pkg`:
  - State enum `fetch_state_t` (`S_REQ`, `S_WAIT`, `S_HOLD`, `S_DRAIN`).
  - Constant `INSTR_BYTES=4`.
  - Default `RESET_PC`.
- Sub-module `pc_incrementer`: combinational `ADDR_WIDTH` adder, `pc + INSTR_BYTES`, carry discarded. This is the same add-4 function already used in the PC path.
- FSM, PC register and output buffer live in the top module.

## Test plan
- Reset with `RESET_PC=0`; memory returns the word `addr^32'hA5A5_0000` one cycle after accept; `instr_ready=1`.
  - Expect `instr_pc` = 0, 4, 8, 12 with matching data, one instruction every 3 cycles.
- Stall: hold `instr_ready=0` for 5 cycles on the instruction at PC=8.
  - `instr_valid`, `instr_data` and `instr_pc` stay stable.
  - No new request is issued.
  - The next request after release uses addr 12.
- Redirect to `0x1003` while in `S_WAIT`.
  - The response for the old PC is dropped.
  - The next request uses addr `0x1000`; the next instruction has `instr_pc=0x1000`.
- Redirect in the same cycle as the `S_REQ` handshake.
  - The block enters `S_DRAIN`; the stale response is discarded.
  - The next request is to the redirect target.
- Redirect in `S_HOLD` with `instr_ready=1`.
  - The buffered instruction is not delivered; `instr_valid=0` the next cycle.
- Wrap-around: `RESET_PC=64'hFFFF_FFFF_FFFF_FFFC`.
  - `instr_pc` sequence is `...FFFC`, then 0, then 4.
- Async reset asserted mid-`S_WAIT`.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the first request is to `RESET_PC`.
